// File: rtl/json_io_pkg.sv
// json_io_pkg: byte and arbiter-state types shared by the JSON stream blocks
package json_io_pkg;
    localparam int BYTE_W = 8;
    typedef logic [7:0] byte_t;
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/json_stream_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first set request above the previous winner
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             any,
    output logic [ID_W-1:0]  idx
);
    assign any = |req;
    // walk from the farthest candidate back to last+1 so the nearest set bit overrides
    always_comb begin
        idx = '0;
        for (int k = N_REQ; k >= 1; k--)
            idx = req[(int'(last) + k) % N_REQ] ? ID_W'((int'(last) + k) % N_REQ) : idx;
    end
endmodule

// File: rtl/json_stream_arbiter.sv
// json_stream_arbiter: frame-granular round-robin sharing of one byte sink among N_REQ producers,
// with a one-entry output register and per-frame length/source reporting.
module json_stream_arbiter
    import json_io_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ),
    parameter int LEN_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   s_valid,
    input  logic [N_REQ*8-1:0] s_data,
    input  logic [N_REQ-1:0]   s_last,
    output logic [N_REQ-1:0]   s_ready,
    output logic               m_valid,
    output logic [7:0]         m_data,
    output logic               m_last,
    output logic [ID_W-1:0]    m_id,
    input  logic               m_ready,
    output logic               busy,
    output logic               done_valid,
    output logic [ID_W-1:0]    done_id,
    output logic [LEN_W-1:0]   done_len,
    output logic               done_sat
);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    arb_state_e       state;
    logic [ID_W-1:0]  grant, last_grant, pick;
    logic             pick_any;
    logic [LEN_W-1:0] len_cnt, len_inc;
    logic             sat, sat_inc;
    logic             take, accept, cur_valid, cur_last;
    byte_t            cur_data;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req(s_valid), .last(last_grant), .any(pick_any), .idx(pick)
    );

    assign busy    = (state == ARB_LOCKED);
    assign take    = busy && (!m_valid || m_ready);
    assign accept  = take && cur_valid;
    assign len_inc = (len_cnt == LEN_MAX) ? len_cnt : len_cnt + LEN_W'(1);
    assign sat_inc = sat || (len_cnt == LEN_MAX);

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        s_ready   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cur_valid  = (grant == ID_W'(i)) ? s_valid[i] : cur_valid;
            cur_last   = (grant == ID_W'(i)) ? s_last[i] : cur_last;
            cur_data   = (grant == ID_W'(i)) ? s_data[i*8 +: 8] : cur_data;
            s_ready[i] = take && (grant == ID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            len_cnt    <= '0;
            sat        <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_id       <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_len   <= '0;
            done_sat   <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= cur_data;
                m_last  <= cur_last;
                m_id    <= grant;
                len_cnt <= len_inc;
                sat     <= sat_inc;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (accept && cur_last) begin
                done_valid <= 1'b1;
                done_id    <= grant;
                done_len   <= len_inc;
                done_sat   <= sat_inc;
                last_grant <= grant;
                state      <= ARB_IDLE;
            end
            // arbitration consumes the whole IDLE cycle; no byte moves here
            if (state == ARB_IDLE && pick_any) begin
                state   <= ARB_LOCKED;
                grant   <= pick;
                len_cnt <= '0;
                sat     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_json_stream_arbiter.sv
// tb_json_stream_arbiter: frame-level reference model with directed scenarios and random traffic
module tb_json_stream_arbiter;
    import json_io_pkg::*;
    localparam int N = 4;
    localparam int IW = 2;
    localparam int LW = 4;
    localparam int LMAX = (1 << LW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   s_valid, s_last, s_ready;
    logic [N*8-1:0] s_data;
    logic           m_valid, m_last, m_ready, busy, done_valid, done_sat;
    logic [7:0]     m_data;
    logic [IW-1:0]  m_id, done_id;
    logic [LW-1:0]  done_len;

    json_stream_arbiter #(.N_REQ(N), .ID_W(IW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_id(m_id),
        .m_ready(m_ready), .busy(busy), .done_valid(done_valid), .done_id(done_id),
        .done_len(done_len), .done_sat(done_sat)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // requester side: each requester holds at most one pending frame
    byte_t fq[N][$];
    int    flen[N];
    bit    gen_en[N];
    bit    stall[N];
    int    gen_p = 100;
    int    gen_len = 0;
    int    vp = 100;
    int    rmode = 0;
    int    acc_cnt = 0;

    // reference model of what the sink should see
    bit    ml_lock, mv, mlast, dv, dsat;
    int    ml_g, ml_last_g, mid, did, dlen;
    byte_t md;

    task automatic model_reset();
        ml_lock = 0; mv = 0; mlast = 0; dv = 0; dsat = 0;
        ml_g = 0; ml_last_g = N - 1; mid = 0; did = 0; dlen = 0; md = 0;
    endtask

    function automatic int rr_model(int last, logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    task automatic new_frame(int i, int len);
        fq[i].delete();
        for (int k = 0; k < len; k++) fq[i].push_back(byte_t'($urandom_range(32, 126)));
        flen[i] = len;
    endtask

    task automatic chk_zero(string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_id"}, m_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_done_valid"}, done_valid, 0);
        check({tag, "_done_id"}, done_id, 0);
        check({tag, "_done_len"}, done_len, 0);
        check({tag, "_done_sat"}, done_sat, 0);
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        bit acc, locked0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (gen_en[i] && fq[i].size() == 0 && int'($urandom_range(99)) < gen_p)
                new_frame(i, gen_len != 0 ? gen_len : int'($urandom_range(1, 20)));
            s_valid[i] = fq[i].size() > 0 && !stall[i] && int'($urandom_range(99)) < vp;
            s_data[i*8 +: 8] = fq[i].size() > 0 ? fq[i][0] : 8'h00;
            s_last[i] = fq[i].size() == 1;
        end
        m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(1)) : rmode == 2 ? ~m_ready : 1'b0;
        #1;
        exp_rdy = '0;
        if (ml_lock && (!mv || m_ready)) exp_rdy[ml_g] = 1'b1;
        check("s_ready", s_ready, exp_rdy);
        locked0 = ml_lock;
        acc = ml_lock && s_valid[ml_g] && (!mv || m_ready);
        dv = 0;
        if (acc) begin
            mv = 1; md = fq[ml_g][0]; mlast = s_last[ml_g]; mid = ml_g;
            if (mlast) begin
                dv = 1; did = ml_g;
                dlen = flen[ml_g] > LMAX ? LMAX : flen[ml_g];
                dsat = flen[ml_g] > LMAX;
                ml_lock = 0; ml_last_g = ml_g;
            end
        end else if (m_ready) mv = 0;
        if (!locked0 && |s_valid) begin
            ml_g = rr_model(ml_last_g, s_valid);
            ml_lock = 1;
        end
        for (int i = 0; i < N; i++)
            if (s_valid[i] && s_ready[i]) begin
                void'(fq[i].pop_front());
                acc_cnt++;
            end
        @(posedge clk);
        #1;
        check("m_valid", m_valid, mv);
        check("busy", busy, ml_lock);
        check("done_valid", done_valid, dv);
        if (mv) begin
            check("m_data", m_data, md);
            check("m_last", m_last, mlast);
            check("m_id", m_id, mid);
        end
        if (dv) begin
            check("done_id", done_id, did);
            check("done_len", done_len, dlen);
            check("done_sat", done_sat, dsat);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += fq[i].size();
        return s;
    endfunction

    task automatic drain();
        int k = 0;
        vp = 100; rmode = 0;
        for (int i = 0; i < N; i++) begin gen_en[i] = 0; stall[i] = 0; end
        while ((pending() > 0 || ml_lock || mv) && k < 400) begin step(); k++; end
        check("drain_done", k < 400, 1);
    endtask

    task automatic apply_reset(string tag);
        rst_n = 1'b0;
        s_valid = '0;
        #1;
        chk_zero(tag);
        model_reset();
        for (int i = 0; i < N; i++) fq[i].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b0;
        for (int i = 0; i < N; i++) begin gen_en[i] = 0; stall[i] = 0; flen[i] = 0; end
        model_reset();
        #1;
        apply_reset("por");

        // "{}" from requester 0
        fq[0] = '{8'h7B, 8'h7D}; flen[0] = 2;
        repeat (6) step();

        // back-to-back 3-byte frames on 0, 1, 3
        gen_p = 100; gen_len = 3;
        gen_en[0] = 1; gen_en[1] = 1; gen_en[3] = 1;
        repeat (30) step();
        drain();

        // backpressure: hold for 5 cycles, then toggle m_ready
        new_frame(1, 12);
        repeat (4) step();
        rmode = 3;
        repeat (5) step();
        rmode = 2;
        repeat (20) step();
        drain();

        // length saturation then a clean frame
        new_frame(2, 20);
        drain();
        new_frame(2, 3);
        drain();

        // reset after 2 of 4 bytes; requester 0 must win afterwards
        new_frame(2, 4);
        acc_cnt = 0; k = 0;
        while (acc_cnt < 2 && k < 50) begin step(); k++; end
        check("mid_frame_reached", acc_cnt, 2);
        apply_reset("mid_rst");
        new_frame(0, 3); new_frame(2, 3);
        step();
        check("post_rst_grant0", busy, 1);
        drain();

        // granted requester stalls while another requests
        new_frame(1, 6);
        acc_cnt = 0; k = 0;
        while (acc_cnt < 2 && k < 50) begin step(); k++; end
        new_frame(3, 4);
        stall[1] = 1;
        repeat (10) step();
        stall[1] = 0;
        drain();

        // random traffic
        gen_p = 30; gen_len = 0; vp = 70; rmode = 1;
        for (int i = 0; i < N; i++) gen_en[i] = 1;
        repeat (1500) step();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
